// File: rtl/nios2_cpu_div_cell.sv
// Radix-2 restoring divider for the Nios II execute stage (div/divu).
// Operands are latched on an accepted start; the result arrives DATA_WIDTH+2 cycles later.
module nios2_cpu_div_cell #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] E_src1,
  input  logic [DATA_WIDTH-1:0] E_src2,
  input  logic                  E_div_start,
  input  logic                  E_div_signed,
  input  logic                  E_div_kill,
  output logic                  M_div_busy,
  output logic                  M_div_done,
  output logic [DATA_WIDTH-1:0] M_div_quot,
  output logic [DATA_WIDTH-1:0] M_div_rem
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_divd;
  logic [DATA_WIDTH-1:0] r_dvsr;
  logic [DATA_WIDTH:0]   r_rem;
  logic [DATA_WIDTH-1:0] r_src1;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_dz;

  logic [DATA_WIDTH-1:0] w_abs1;
  logic [DATA_WIDTH-1:0] w_abs2;
  logic [DATA_WIDTH+1:0] w_shift;
  logic [DATA_WIDTH+1:0] w_trial;
  logic                  w_ge;
  logic [DATA_WIDTH:0]   w_rem_next;
  logic [DATA_WIDTH-1:0] w_q_fix;
  logic [DATA_WIDTH-1:0] w_r_fix;

  // Operand magnitudes, one trial-subtract step, and the sign/zero result fix-up.
  always_comb begin
    w_abs1     = E_src1;
    w_abs2     = E_src2;
    w_shift    = {r_rem, r_divd[DATA_WIDTH-1]};
    w_trial    = w_shift - {2'b00, r_dvsr};
    w_ge       = ~w_trial[DATA_WIDTH+1];
    w_rem_next = w_shift[DATA_WIDTH:0];
    w_q_fix    = r_divd;
    w_r_fix    = r_rem[DATA_WIDTH-1:0];
    if (E_div_signed && E_src1[DATA_WIDTH-1]) begin
      w_abs1 = -E_src1;
    end else begin
      w_abs1 = E_src1;
    end
    if (E_div_signed && E_src2[DATA_WIDTH-1]) begin
      w_abs2 = -E_src2;
    end else begin
      w_abs2 = E_src2;
    end
    if (w_ge) begin
      w_rem_next = w_trial[DATA_WIDTH:0];
    end else begin
      w_rem_next = w_shift[DATA_WIDTH:0];
    end
    // Divide by zero reports all-ones and the untouched dividend, regardless of signedness.
    if (r_dz) begin
      w_q_fix = {DATA_WIDTH{1'b1}};
      w_r_fix = r_src1;
    end else begin
      w_q_fix = r_neg_q ? -r_divd : r_divd;
      w_r_fix = r_neg_r ? -r_rem[DATA_WIDTH-1:0] : r_rem[DATA_WIDTH-1:0];
    end
  end

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= {CW{1'b0}};
      r_divd     <= {DATA_WIDTH{1'b0}};
      r_dvsr     <= {DATA_WIDTH{1'b0}};
      r_rem      <= {(DATA_WIDTH+1){1'b0}};
      r_src1     <= {DATA_WIDTH{1'b0}};
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      M_div_busy <= 1'b0;
      M_div_done <= 1'b0;
      M_div_quot <= {DATA_WIDTH{1'b0}};
      M_div_rem  <= {DATA_WIDTH{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          M_div_done <= 1'b0;
          if (E_div_start) begin
            r_divd     <= w_abs1;
            r_dvsr     <= w_abs2;
            r_src1     <= E_src1;
            r_neg_q    <= E_div_signed & (E_src1[DATA_WIDTH-1] ^ E_src2[DATA_WIDTH-1]);
            r_neg_r    <= E_div_signed & E_src1[DATA_WIDTH-1];
            r_dz       <= (E_src2 == {DATA_WIDTH{1'b0}});
            r_rem      <= {(DATA_WIDTH+1){1'b0}};
            r_cnt      <= CW'(DATA_WIDTH - 1);
            M_div_busy <= 1'b1;
            r_state    <= S_ITER;
          end else begin
            M_div_busy <= 1'b0;
          end
        end
        S_ITER: begin
          if (E_div_kill) begin
            M_div_busy <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_rem  <= w_rem_next;
            r_divd <= {r_divd[DATA_WIDTH-2:0], w_ge};
            if (r_cnt == {CW{1'b0}}) begin
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        S_FIX: begin
          if (E_div_kill) begin
            M_div_busy <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            M_div_quot <= w_q_fix;
            M_div_rem  <= w_r_fix;
            M_div_done <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          M_div_done <= 1'b0;
          M_div_busy <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          M_div_done <= 1'b0;
          M_div_busy <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
